// File: rtl/branch_predictor_pkg.sv
// Shared types and constants for the branch predictor: FSM state type and
// the encodings of the 2-bit saturating direction counter.
package branch_predictor_pkg;

    // INIT sweeps the table clear; READY serves predictions and updates.
    typedef enum logic [0:0] {
        INIT  = 1'b0,
        READY = 1'b1
    } bp_state_t;

    // Counter bit 1 is the taken/not-taken prediction.
    localparam logic [1:0] CNT_STRONG_NT = 2'b00;
    localparam logic [1:0] CNT_WEAK_NT   = 2'b01;
    localparam logic [1:0] CNT_WEAK_T    = 2'b10;
    localparam logic [1:0] CNT_STRONG_T  = 2'b11;

endpackage

// File: rtl/branch_predictor_counter.sv
// Next-state logic of a 2-bit saturating direction counter: step toward
// strong-taken on a taken outcome, toward strong-not-taken otherwise.
module bp_counter
    import branch_predictor_pkg::*;
(
    input  logic [1:0] cnt,
    input  logic       taken,
    output logic [1:0] cntNext
);

    // Saturating increment/decrement; the end states hold their value.
    always_comb begin
        cntNext = cnt;
        if (taken) begin
            if (cnt != CNT_STRONG_T) cntNext = cnt + 2'd1;
        end else begin
            if (cnt != CNT_STRONG_NT) cntNext = cnt - 2'd1;
        end
    end

endmodule

// File: rtl/branch_predictor.sv
// Direct-mapped, tagged branch predictor with per-entry target and 2-bit
// direction counter. Lookups are combinational and read the table as it was
// before any same-cycle update. After reset or a flush the table is cleared
// one entry per cycle (INIT) before predictions and updates are enabled.
//
// Handshake: updateValid is a single-cycle strobe with no back-pressure; it is
// honoured only while ready=1 and flushAll=0, otherwise it is silently dropped.
module branch_predictor
    import branch_predictor_pkg::*;
#(
    parameter int BHT_DEPTH  = 64,
    parameter int ADDR_WIDTH = 32,
    parameter int TAG_WIDTH  = 8
) (
    input  logic                  clk,
    input  logic                  rstN,
    input  logic                  flushAll,
    output logic                  ready,
    input  logic [ADDR_WIDTH-1:0] lookupPc,
    output logic                  predHit,
    output logic                  predTaken,
    output logic [ADDR_WIDTH-1:0] predTarget,
    input  logic                  updateValid,
    input  logic [ADDR_WIDTH-1:0] updatePc,
    input  logic                  updateTaken,
    input  logic [ADDR_WIDTH-1:0] updateTarget,
    output bp_state_t             dbgState
);

    localparam int IDX = $clog2(BHT_DEPTH);
    localparam logic [IDX-1:0] LAST_IDX = IDX'(BHT_DEPTH - 1);

    // Table storage: plain registers, cleared by the INIT sweep, not by reset.
    logic                  validArr  [BHT_DEPTH];
    logic [TAG_WIDTH-1:0]  tagArr    [BHT_DEPTH];
    logic [ADDR_WIDTH-1:0] targetArr [BHT_DEPTH];
    logic [1:0]            cntArr    [BHT_DEPTH];

    bp_state_t      state;
    logic [IDX-1:0] sweepIdx;

    logic [IDX-1:0]       lkIdx;
    logic [TAG_WIDTH-1:0] lkTag;
    logic [IDX-1:0]       upIdx;
    logic [TAG_WIDTH-1:0] upTag;
    logic                 upEntryHit;
    logic                 doUpdate;
    logic [1:0]           upCntNext;

    assign ready    = (state == READY);
    assign dbgState = state;

    // PC bits [1:0] are always zero for aligned instructions, so skip them.
    assign lkIdx = lookupPc[IDX+1:2];
    assign lkTag = lookupPc[IDX+TAG_WIDTH+1:IDX+2];
    assign upIdx = updatePc[IDX+1:2];
    assign upTag = updatePc[IDX+TAG_WIDTH+1:IDX+2];

    // Zero-latency prediction from the current table contents.
    always_comb begin
        predHit    = ready && validArr[lkIdx] && (tagArr[lkIdx] == lkTag);
        predTaken  = predHit && cntArr[lkIdx][1];
        predTarget = predTaken ? targetArr[lkIdx] : (lookupPc + ADDR_WIDTH'(4));
    end

    assign upEntryHit = validArr[upIdx] && (tagArr[upIdx] == upTag);
    // A flush in the same cycle wins over the update.
    assign doUpdate   = ready && updateValid && !flushAll;

    bp_counter uCounter (
        .cnt     (cntArr[upIdx]),
        .taken   (updateTaken),
        .cntNext (upCntNext)
    );

    // Table writes: sweep clear in INIT, train/allocate in READY.
    always_ff @(posedge clk) begin
        if (state == INIT) begin
            validArr[sweepIdx] <= 1'b0;
            cntArr[sweepIdx]   <= CNT_WEAK_NT;
        end else if (doUpdate) begin
            if (upEntryHit) begin
                cntArr[upIdx] <= upCntNext;
                if (updateTaken) targetArr[upIdx] <= updateTarget;
            end else if (updateTaken) begin
                validArr[upIdx]  <= 1'b1;
                tagArr[upIdx]    <= upTag;
                targetArr[upIdx] <= updateTarget;
                cntArr[upIdx]    <= CNT_WEAK_T;
            end
        end
    end

    // Control FSM: INIT sweeps every index once, then READY until a flush.
    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            state    <= INIT;
            sweepIdx <= '0;
        end else begin
            case (state)
                INIT: begin
                    if (flushAll) begin
                        sweepIdx <= '0;
                    end else if (sweepIdx == LAST_IDX) begin
                        sweepIdx <= '0;
                        state    <= READY;
                    end else begin
                        sweepIdx <= sweepIdx + 1'b1;
                    end
                end
                READY: begin
                    if (flushAll) begin
                        state    <= INIT;
                        sweepIdx <= '0;
                    end
                end
                default: begin
                    state    <= INIT;
                    sweepIdx <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_branch_predictor.sv
// Self-checking bench for branch_predictor: directed scenarios with literal
// expectations plus randomized traffic, all checked every cycle against a
// behavioural table model.
module tb_branch_predictor;

    localparam int DEPTH = 64;

    logic        clk = 1'b0;
    logic        rstN = 1'b0;
    logic        flushAll = 1'b0;
    logic        updateValid = 1'b0;
    logic        updateTaken = 1'b0;
    logic [31:0] lookupPc = '0;
    logic [31:0] updatePc = '0;
    logic [31:0] updateTarget = '0;
    logic        ready;
    logic        predHit;
    logic        predTaken;
    logic [31:0] predTarget;
    branch_predictor_pkg::bp_state_t dbgState;

    int tests = 0;
    int fails = 0;

    // ---------------- clock ----------------
    always #5 clk = ~clk;

    branch_predictor #(
        .BHT_DEPTH  (DEPTH),
        .ADDR_WIDTH (32),
        .TAG_WIDTH  (8)
    ) dut (
        .clk          (clk),
        .rstN         (rstN),
        .flushAll     (flushAll),
        .ready        (ready),
        .lookupPc     (lookupPc),
        .predHit      (predHit),
        .predTaken    (predTaken),
        .predTarget   (predTarget),
        .updateValid  (updateValid),
        .updatePc     (updatePc),
        .updateTaken  (updateTaken),
        .updateTarget (updateTarget),
        .dbgState     (dbgState)
    );

    // ---------------- behavioural model ----------------
    // Table as plain arrays; the init sweep is modelled only as a count of
    // cycles left before the table becomes visible again.
    bit          mValid  [DEPTH];
    int          mTag    [DEPTH];
    logic [31:0] mTarget [DEPTH];
    int          mCnt    [DEPTH];
    int          initLeft = DEPTH;

    function automatic int pcIdx(input logic [31:0] pc);
        return int'((pc >> 2) % DEPTH);
    endfunction

    function automatic int pcTag(input logic [31:0] pc);
        return int'((pc >> 8) % 256);
    endfunction

    task automatic enterInit();
        initLeft = DEPTH;
        for (int i = 0; i < DEPTH; i++) begin
            mValid[i] = 1'b0;
            mCnt[i]   = 1;
        end
    endtask

    // Model state advance on each rising edge, from the inputs held there.
    always @(posedge clk) begin
        if (!rstN) begin
            enterInit();
        end else if (initLeft > 0) begin
            if (flushAll) initLeft = DEPTH;
            else          initLeft = initLeft - 1;
        end else if (flushAll) begin
            enterInit();
        end else if (updateValid) begin
            int ix;
            int tg;
            ix = pcIdx(updatePc);
            tg = pcTag(updatePc);
            if (mValid[ix] && mTag[ix] == tg) begin
                if (updateTaken) begin
                    mCnt[ix]    = (mCnt[ix] == 3) ? 3 : mCnt[ix] + 1;
                    mTarget[ix] = updateTarget;
                end else begin
                    mCnt[ix] = (mCnt[ix] == 0) ? 0 : mCnt[ix] - 1;
                end
            end else if (updateTaken) begin
                mValid[ix]  = 1'b1;
                mTag[ix]    = tg;
                mTarget[ix] = updateTarget;
                mCnt[ix]    = 2;
            end
        end
    end

    // ---------------- scoreboard ----------------
    task automatic checkVal(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic compareModel();
        int          ix;
        int          tg;
        bit          rdy;
        bit          hit;
        bit          tk;
        logic [31:0] tgt;
        ix  = pcIdx(lookupPc);
        tg  = pcTag(lookupPc);
        rdy = rstN && (initLeft == 0);
        hit = rdy && mValid[ix] && (mTag[ix] == tg);
        tk  = hit && (mCnt[ix] >= 2);
        tgt = tk ? mTarget[ix] : lookupPc + 32'd4;
        checkVal("ready", 32'(ready), 32'(rdy));
        checkVal("predHit", 32'(predHit), 32'(hit));
        checkVal("predTaken", 32'(predTaken), 32'(tk));
        checkVal("predTarget", predTarget, tgt);
    endtask

    // ---------------- driver tasks ----------------
    // Drive one cycle's inputs on the falling edge, then compare the
    // combinational outputs against the model before the next rising edge.
    task automatic cyc(input logic rn, input logic fl, input logic uv,
                       input logic [31:0] upc, input logic utk,
                       input logic [31:0] utg, input logic [31:0] lpc);
        @(negedge clk);
        rstN         = rn;
        flushAll     = fl;
        updateValid  = uv;
        updatePc     = upc;
        updateTaken  = utk;
        updateTarget = utg;
        lookupPc     = lpc;
        #1;
        compareModel();
    endtask

    task automatic idle(input logic [31:0] lpc);
        cyc(1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, lpc);
    endtask

    task automatic upd(input logic [31:0] upc, input logic utk,
                       input logic [31:0] utg, input logic [31:0] lpc);
        cyc(1'b1, 1'b0, 1'b1, upc, utk, utg, lpc);
    endtask

    // Count idle cycles with ready low; bounded so a stuck FSM still ends.
    task automatic countLow(input string name);
        int n;
        n = 0;
        for (int k = 0; k < 200; k++) begin
            idle($urandom());
            if (ready === 1'b1) break;
            n++;
        end
        checkVal(name, 32'(n), 32'(DEPTH));
    endtask

    function automatic logic [31:0] randPc();
        logic [31:0] p;
        p       = $urandom();
        p[1:0]  = 2'b00;
        p[7:2]  = 6'($urandom_range(0, 7));
        p[15:8] = 8'($urandom_range(0, 2));
        return p;
    endfunction

    // ---------------- stimulus ----------------
    initial begin
        int          rstHold;
        logic        rn;
        logic        fl;
        logic        uv;
        logic        utk;
        logic [31:0] upc;
        logic [31:0] utg;

        // Reset held: nothing predicted.
        for (int i = 0; i < 3; i++) cyc(1'b0, 1'b0, 1'b1, 32'h100, 1'b1, 32'h40, 32'h100);
        checkVal("rst_ready", 32'(ready), 32'd0);
        checkVal("rst_predHit", 32'(predHit), 32'd0);

        // Release: exactly DEPTH cycles of sweep before ready.
        countLow("init_len");

        // Allocate 0x100 -> target 0x40; lookup in the same cycle sees the old table.
        upd(32'h100, 1'b1, 32'h40, 32'h100);
        checkVal("alloc_same_cycle_hit", 32'(predHit), 32'd0);
        idle(32'h100);
        checkVal("alloc_hit", 32'(predHit), 32'd1);
        checkVal("alloc_taken", 32'(predTaken), 32'd1);
        checkVal("alloc_target", predTarget, 32'h40);
        idle(32'h104);
        checkVal("next_taken", 32'(predTaken), 32'd0);
        checkVal("next_target", predTarget, 32'h108);

        // Not-taken training: 10 -> 01 -> 00 -> 00, never wrapping.
        upd(32'h100, 1'b0, 32'h0, 32'h100);
        checkVal("nt1_taken", 32'(predTaken), 32'd1);
        upd(32'h100, 1'b0, 32'h0, 32'h100);
        checkVal("nt2_taken", 32'(predTaken), 32'd0);
        upd(32'h100, 1'b0, 32'h0, 32'h100);
        checkVal("nt3_hit", 32'(predHit), 32'd1);
        upd(32'h100, 1'b0, 32'h0, 32'h100);
        checkVal("nt4_taken", 32'(predTaken), 32'd0);
        upd(32'h100, 1'b1, 32'h40, 32'h100);
        checkVal("sat_low_taken", 32'(predTaken), 32'd0);
        upd(32'h100, 1'b1, 32'h40, 32'h100);
        checkVal("climb1_taken", 32'(predTaken), 32'd0);
        idle(32'h100);
        checkVal("climb2_taken", 32'(predTaken), 32'd1);

        // Aliasing: 0x200 shares the index of 0x100 with a different tag.
        idle(32'h200);
        checkVal("alias_miss", 32'(predHit), 32'd0);
        upd(32'h200, 1'b1, 32'h80, 32'h200);
        checkVal("alias_same_cycle_hit", 32'(predHit), 32'd0);
        idle(32'h200);
        checkVal("alias_new_hit", 32'(predHit), 32'd1);
        checkVal("alias_new_target", predTarget, 32'h80);
        idle(32'h100);
        checkVal("alias_old_miss", 32'(predHit), 32'd0);

        // Flush in READY (its update is dropped), then re-flush at sweep index 30.
        cyc(1'b1, 1'b1, 1'b1, 32'h300, 1'b1, 32'h500, 32'h200);
        for (int j = 1; j <= 31; j++) begin
            cyc(1'b1, (j == 31), 1'b0, 32'h0, 1'b0, 32'h0, $urandom());
        end
        checkVal("reflush_ready", 32'(ready), 32'd0);
        countLow("reflush_len");
        idle(32'h200);
        checkVal("post_flush_miss", 32'(predHit), 32'd0);
        idle(32'h300);
        checkVal("dropped_update_miss", 32'(predHit), 32'd0);
        idle(32'hFFFF_FFFC);
        checkVal("wrap_target", predTarget, 32'h0);

        // Randomized traffic with occasional flushes and resets.
        rstHold = 0;
        for (int i = 0; i < 3000; i++) begin
            rn = 1'b1;
            if (rstHold > 0) begin
                rn = 1'b0;
                rstHold--;
            end else if ($urandom_range(0, 699) == 0) begin
                rn = 1'b0;
                rstHold = $urandom_range(1, 3);
            end
            fl  = ($urandom_range(0, 299) == 0);
            uv  = ($urandom_range(0, 1) == 1);
            utk = ($urandom_range(0, 2) != 0);
            upc = randPc();
            utg = $urandom();
            cyc(rn, fl, uv, upc, utk, utg, randPc());
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
